// File: rtl/gf_array_pkg.sv
// gf_array_pkg: shared field width default, lane/slot slicing helpers and word-packing derivation for the GF array
package gf_array_pkg;

    localparam int GF_BIT_DEFAULT = 4;

    function automatic int lane_lo(input int lane, input int gf_bit);
        return lane * gf_bit;
    endfunction

    function automatic int slot_lo(input int slot, input int vec_w);
        return slot * vec_w;
    endfunction

    function automatic int calc_vpw(input int out_width, input int vec_w);
        return out_width / vec_w;
    endfunction

    function automatic bit width_ok(input int out_width, input int vec_w);
        return vec_w > 0 && out_width >= vec_w && out_width % vec_w == 0;
    endfunction

endpackage

// File: rtl/gf_word_fifo.sv
// gf_word_fifo: show-ahead FIFO with occupancy flags; the caller must not push while full without popping
module gf_word_fifo
    import gf_array_pkg::*;
#(
    parameter int W     = 129,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp_q, wp_d, rp_q, rp_d;

    always_comb begin
        count = wp_q - rp_q;
        full  = count == (AW + 1)'(DEPTH);
        empty = wp_q == rp_q;
        rdata = mem[rp_q[AW-1:0]];
        wp_d  = wp_q + (AW + 1)'(push);
        rp_d  = rp_q + (AW + 1)'(pop && !empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/gf_column_collector.sv
// gf_column_collector: de-skews the PE lanes, packs aligned column vectors into words and buffers them for a non-stalling array
module gf_column_collector
    import gf_array_pkg::*;
#(
    parameter int GF_BIT     = GF_BIT_DEFAULT,
    parameter int N          = 16,
    parameter int OUT_WIDTH  = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [N*GF_BIT-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_last,
    output logic                  almost_full,
    output logic                  overflow
);

    localparam int VEC_W = N * GF_BIT;
    localparam int VPW   = calc_vpw(OUT_WIDTH, VEC_W);
    localparam int SW    = VPW > 1 ? $clog2(VPW) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    if (!width_ok(OUT_WIDTH, VEC_W)) begin : g_bad_width
        $error("OUT_WIDTH must be a multiple of N*GF_BIT");
    end

    logic [VEC_W-1:0] a_vec;
    logic             a_valid, a_last;

    // lane i lags lane 0 by i cycles, so it needs N-1-i stages to line up
    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam int D = N - 1 - i;
        if (D == 0) begin : g_pass
            assign a_vec[lane_lo(i, GF_BIT) +: GF_BIT] = in_data[lane_lo(i, GF_BIT) +: GF_BIT];
        end else begin : g_dly
            logic [D*GF_BIT-1:0] sr_q, sr_d;
            always_comb sr_d = (sr_q << GF_BIT) | (D * GF_BIT)'(in_data[lane_lo(i, GF_BIT) +: GF_BIT]);
            always_ff @(posedge clk or posedge rst) begin
                if (rst) sr_q <= '0;
                else     sr_q <= sr_d;
            end
            assign a_vec[lane_lo(i, GF_BIT) +: GF_BIT] = sr_q[D*GF_BIT-1 -: GF_BIT];
        end
    end

    if (N == 1) begin : g_ctl_pass
        assign a_valid = in_valid;
        assign a_last  = in_valid && in_last;
    end else begin : g_ctl_dly
        logic [2*(N-1)-1:0] vl_q, vl_d;
        always_comb vl_d = (vl_q << 2) | (2 * (N - 1))'({in_valid, in_valid && in_last});
        always_ff @(posedge clk or posedge rst) begin
            if (rst) vl_q <= '0;
            else     vl_q <= vl_d;
        end
        assign {a_valid, a_last} = vl_q[2*(N-1)-1 -: 2];
    end

    logic [SW-1:0]        slot_q, slot_d;
    logic [OUT_WIDTH-1:0] stage_q, stage_d, word;
    logic                 push, push_ok, pop, af_q, af_d, ovf_q, ovf_d;
    logic [CW-1:0]        count, cnt_next;
    logic                 full, empty;
    logic [OUT_WIDTH:0]   head;

    always_comb begin
        word     = stage_q | (OUT_WIDTH'(a_vec) << slot_lo(int'(slot_q), VEC_W));
        push     = a_valid && (a_last || slot_q == SW'(VPW - 1));
        slot_d   = !a_valid ? slot_q  : push ? '0 : slot_q + 1'b1;
        stage_d  = !a_valid ? stage_q : push ? '0 : word;
        pop      = !empty && out_ready;
        push_ok  = push && (!full || pop);
        cnt_next = count + CW'(push_ok) - CW'(pop);
        af_d     = cnt_next >= CW'(FIFO_DEPTH - 1);
        ovf_d    = ovf_q || (push && !push_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q  <= '0;
            stage_q <= '0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            stage_q <= stage_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end

    gf_word_fifo #(.W(OUT_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .pop   (pop),
        .wdata ({a_last, word}),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // memory contents are not reset, so the head is masked while empty
    assign out_valid   = !empty;
    assign out_data    = empty ? '0 : head[OUT_WIDTH-1:0];
    assign out_last    = !empty && head[OUT_WIDTH];
    assign almost_full = af_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_gf_column_collector.sv
// tb_gf_column_collector: directed checks of de-skew, packing, FIFO flags and reset for N=4, GF_BIT=4, OUT_WIDTH=32
module tb_gf_column_collector;

    logic        clk, rst, in_valid, in_last, out_valid, out_ready, out_last, almost_full, overflow;
    logic [15:0] in_data;
    logic [31:0] out_data;

    gf_column_collector #(.GF_BIT(4), .N(4), .OUT_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .almost_full(almost_full), .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          t;
    logic        sv [0:1023];
    logic        sl [0:1023];
    logic [15:0] sd [0:1023];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_from(input int c);
        for (int k = c; k < 1024; k++) begin
            sv[k] = 1'b0;
            sl[k] = 1'b0;
            sd[k] = '0;
        end
    endtask

    // lane i of a vector flagged at cycle tv is driven at cycle tv+i
    task automatic put_vec(input int tv, input logic last, input logic [15:0] v);
        sv[tv] = 1'b1;
        sl[tv] = last;
        for (int i = 0; i < 4; i++) sd[tv+i][i*4 +: 4] = v[i*4 +: 4];
    endtask

    task automatic tick();
        in_valid = sv[cyc];
        in_last  = sl[cyc];
        in_data  = sd[cyc];
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    initial begin
        clear_from(0);
        rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_almost_full", almost_full, 0);
        chk("rst_overflow", overflow, 0);
        tick(); tick();
        rst = 1'b0;

        // two-vector burst
        out_ready = 1'b1;
        t = cyc + 1;
        put_vec(t, 1'b0, 16'h4321);
        put_vec(t + 1, 1'b1, 16'hDCBA);
        run_to(t + 4); chk("b2_not_yet", out_valid, 0);
        tick();
        chk("b2_valid", out_valid, 1);
        chk("b2_data", out_data, 32'hDCBA4321);
        chk("b2_last", out_last, 1);
        tick(); chk("b2_drained", out_valid, 0);

        // three-vector burst, last on the third
        t = cyc + 1;
        put_vec(t, 1'b0, 16'h4321);
        put_vec(t + 1, 1'b0, 16'hDCBA);
        put_vec(t + 2, 1'b1, 16'h8765);
        run_to(t + 5);
        chk("b3_w1_data", out_data, 32'hDCBA4321);
        chk("b3_w1_last", out_last, 0);
        tick();
        chk("b3_w2_valid", out_valid, 1);
        chk("b3_w2_data", out_data, 32'h00008765);
        chk("b3_w2_last", out_last, 1);
        tick(); chk("b3_drained", out_valid, 0);

        // full FIFO with a pop in the same cycle as a push
        out_ready = 1'b0;
        t = cyc + 1;
        for (int k = 0; k < 5; k++) put_vec(t + k, 1'b1, 16'hB000 + 16'(k));
        run_to(t + 7);
        chk("fp_af_full", almost_full, 1);
        chk("fp_head0", out_data, 32'h0000B000);
        out_ready = 1'b1;
        tick();
        chk("fp_no_overflow", overflow, 0);
        chk("fp_af_stays", almost_full, 1);
        chk("fp_head1", out_data, 32'h0000B001);
        tick(); chk("fp_head2", out_data, 32'h0000B002);
        tick(); chk("fp_head3", out_data, 32'h0000B003);
        tick(); chk("fp_head4", out_data, 32'h0000B004);
        chk("fp_head4_last", out_last, 1);
        tick(); chk("fp_drained", out_valid, 0);

        // no drain: five pushes into a four-entry FIFO
        out_ready = 1'b0;
        t = cyc + 1;
        for (int k = 0; k < 5; k++) put_vec(t + k, 1'b1, 16'hC000 + 16'(k));
        run_to(t + 5); chk("nd_af_after2", almost_full, 0);
        tick();        chk("nd_af_after3", almost_full, 1);
        tick();        chk("nd_ovf_after4", overflow, 0);
        chk("nd_head_stable", out_data, 32'h0000C000);
        tick();        chk("nd_ovf_after5", overflow, 1);
        chk("nd_head0", out_data, 32'h0000C000);
        out_ready = 1'b1;
        tick(); chk("nd_head1", out_data, 32'h0000C001);
        tick(); chk("nd_head2", out_data, 32'h0000C002);
        tick(); chk("nd_head3", out_data, 32'h0000C003);
        tick(); chk("nd_only4", out_valid, 0);
        chk("nd_ovf_sticky", overflow, 1);

        // asynchronous reset between the two vectors of a burst
        out_ready = 1'b0;
        t = cyc + 1;
        put_vec(t, 1'b1, 16'h5555);
        put_vec(t + 4, 1'b0, 16'h4321);
        put_vec(t + 5, 1'b1, 16'hDCBA);
        run_to(t + 5);
        chk("mr_pre_valid", out_valid, 1);
        chk("mr_pre_data", out_data, 32'h00005555);
        clear_from(cyc);
        #2 rst = 1'b1;
        #1;
        chk("mr_out_valid", out_valid, 0);
        chk("mr_out_data", out_data, 0);
        chk("mr_out_last", out_last, 0);
        chk("mr_almost_full", almost_full, 0);
        chk("mr_overflow", overflow, 0);
        tick(); tick();
        rst = 1'b0;
        out_ready = 1'b1;
        t = cyc + 1;
        put_vec(t, 1'b0, 16'h4321);
        put_vec(t + 1, 1'b1, 16'hDCBA);
        run_to(t + 4); chk("mr_no_stale", out_valid, 0);
        tick();
        chk("mr_data", out_data, 32'hDCBA4321);
        chk("mr_last", out_last, 1);
        tick(); chk("mr_single_word", out_valid, 0);

        // twenty idle cycles between the two vectors
        t = cyc + 1;
        put_vec(t, 1'b0, 16'h4321);
        put_vec(t + 21, 1'b1, 16'hDCBA);
        run_to(t + 12); chk("ig_no_flush", out_valid, 0);
        run_to(t + 24); chk("ig_not_yet", out_valid, 0);
        tick();
        chk("ig_data", out_data, 32'hDCBA4321);
        chk("ig_last", out_last, 1);
        tick(); chk("ig_drained", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gf_column_collector.md
# gf_column_collector

Downstream drain stage for the GF systolic processing array. It captures the registered `data_out` of the last PE of each of `N` lanes, where each lane is skewed one cycle behind the previous one. It de-skews the lanes into aligned `N*GF_BIT` column vectors, packs them into `OUT_WIDTH` words, and buffers those words in a small FIFO behind a valid/ready handshake. The array cannot stall, so the block reports `almost_full` back to the controller and latches a sticky `overflow` error.

## Interface
Parameters:
- `GF_BIT`, 4: field element width (4 or 8).
- `N`, 16: number of lanes (≥1).
- `OUT_WIDTH`, 128: output word width; must be a multiple of `N*GF_BIT`, otherwise elaboration fails. `VPW = OUT_WIDTH/(N*GF_BIT)` is the number of vectors per word.
- `FIFO_DEPTH`, 4: output FIFO entries (power of 2, ≥2).

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset. Asynchronous and active-high.
- `in_valid`, in, 1: a column vector starts; timed with lane 0.
- `in_last`, in, 1: final vector of a burst; timed with lane 0, qualified by `in_valid`.
- `in_data`, in, `N*GF_BIT`: lane `i` occupies bits `[i*GF_BIT +: GF_BIT]`.
- `out_valid`, out, 1: FIFO head is valid.
- `out_ready`, in, 1: consumer accepts the head.
- `out_data`, out, `OUT_WIDTH`: packed word.
- `out_last`, out, 1: word closes a burst.
- `almost_full`, out, 1: FIFO occupancy ≥ `FIFO_DEPTH-1`.
- `overflow`, out, 1: sticky; a word was dropped.

## Operation
- **De-skew**
  - Lane `i` of a vector flagged at cycle t arrives at cycle t+i.
  - Lane `i` is delayed `N-1-i` registers, so all lanes align at cycle a = t+N-1.
  - `in_valid` and `in_last` go through an `N-1`-deep pipeline. For N=1 there are no delay registers.
- **Packer**
  - Holds a slot counter `0..VPW-1` and a staging word.
  - An aligned vector is written into slot k at bits `[k*N*GF_BIT +: N*GF_BIT]`, with slot 0 in the LSBs.
  - When k==`VPW-1` or aligned-last is set, the completed word is pushed with `last`=aligned-last. Slots not written are zero. The counter then returns to 0 and the staging word is cleared.
- **FIFO**
  - Show-ahead. Pop when `out_valid && out_ready`.
  - A push while full with no pop in the same cycle is dropped, and `overflow` goes to 1 until reset.
  - A push while full with a simultaneous pop succeeds.
  - A pop when empty has no effect.
- **Packer states**
  - EMPTY (slot 0, nothing staged) goes to PARTIAL on an aligned valid with VPW>1 and not last.
  - An aligned valid that completes the word (last, or slot `VPW-1`) pushes and returns to EMPTY.
  - PARTIAL persists across idle gaps of any length. No timeout flush.
- **Reset** (any time, including mid-burst): clears the deskew registers, valid/last pipeline, slot counter, staging word and FIFO pointers. Vectors in flight are lost.
  - Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `almost_full`=0, `overflow`=0.

## Timing
- A word is completed by an aligned vector at cycle a and pushed at the edge ending a.
- If the FIFO was empty, `out_valid`=1 from cycle a+1 = t+N, where t is the lane-0 cycle of the completing vector.
- `almost_full` and `overflow` are registered and update the cycle after the causing push/pop.
- Sustained throughput: one vector per cycle in, one word per cycle out when `out_ready`=1.
- `out_data` and `out_last` must be stable while `out_valid && !out_ready`.

## Structure
- Shared package `gf_array_pkg`:
  - `GF_BIT` default.
  - Lane-slice and slot-slice index helpers.
  - `VPW` derivation and the `OUT_WIDTH` divisibility check, reused by the upstream feeder.
- Sub-module `gf_word_fifo`:
  - Synchronous show-ahead FIFO, width `OUT_WIDTH+1`.
  - Provides `count`, `full` and `empty`.
  - The drop-on-full policy lives in the collector, not the FIFO.

## Test plan
Parameters for all tests: N=4, GF_BIT=4, OUT_WIDTH=32, FIFO_DEPTH=4, so VPW=2.

- **Two-vector burst**
  - Stimulus: `in_valid` at t and t+1, `in_last` at t+1. Lane i carries i+1 for the first vector and A+i for the second, each at its skewed cycle.
  - Required: `out_valid` rises at t+5 with `out_data`=32'hDCBA4321, `out_last`=1.
- **Three-vector burst, last on third**
  - Required: word 1 is 32'hDCBA4321 with `out_last`=0. Word 2 is 32'h0000_8765 (lanes 5,6,7,8) with `out_last`=1.
- **No drain**
  - Stimulus: `out_ready`=0, push 5 words.
  - Required: `almost_full`=1 after the 3rd push. `overflow`=1 after the 5th. Draining yields exactly the first 4 words, in order.
- **Full with simultaneous pop**
  - Stimulus: FIFO full, `out_ready`=1 in the same cycle as a push.
  - Required: no overflow, occupancy stays 4, FIFO order preserved.
- **Reset mid-burst**
  - Stimulus: assert `rst` asynchronously between the two vectors of the first test.
  - Required: all outputs are 0 immediately. After release, a fresh two-vector burst produces exactly one correct word with no stale slot.
- **Idle gap**
  - Stimulus: 20 idle cycles between vectors 1 and 2 of a burst.
  - Required: the same single word as the first test.
